// File: rtl/mcs4_fetch_master.sv
// mcs4_fetch_master
//   Bus master that runs MCS-4 instruction fetch cycles. Subcycle ticks come
//   from the falling edge of clk2_pad, sampled on sysclk. Each instruction
//   cycle has eight phases, A1 A2 A3 M1 M2 X1 X2 X3, and the phase counter
//   runs whether or not a fetch is pending. A cycle is active when a request
//   was accepted in the X3 before it. An active cycle drives the 12-bit
//   address in A1..A3 and reads the opcode nibbles in M1/M2.
//
//   Optional feature macro: MCS4_FETCH_IO_EN. When it is defined, a request
//   with req_io_en=1 also drives its 8-bit I/O word in X2/X3.
//
// Ports
//   sysclk              system clock, rising edge
//   poc_pad             synchronous active-high reset
//   clk1_pad/clk2_pad   clockgen phases (only clk2 is needed for ticks)
//   sync_pad            registered, high throughout X3
//   cmrom_pad           ROM command line
//   data_in/out/oe      MCS-4 data bus
//   req_*               host fetch request (valid/ready handshake)
//   rsp_*               completed fetch: one-cycle rsp_valid with held data
module mcs4_fetch_master #(
  parameter int SYSCLK_TCY = 50
) (
  input  logic        sysclk,
  input  logic        poc_pad,
  input  logic        clk1_pad,
  input  logic        clk2_pad,
  output logic        sync_pad,
  output logic        cmrom_pad,
  input  logic [3:0]  data_in,
  output logic [3:0]  data_out,
  output logic        data_oe,
  input  logic        req_valid,
  input  logic [11:0] req_addr,
  output logic        req_ready,
  input  logic        req_io_en,
  input  logic [7:0]  req_io_data,
  output logic        rsp_valid,
  output logic [11:0] rsp_addr,
  output logic [3:0]  rsp_opr,
  output logic [3:0]  rsp_opa
);

  typedef enum logic [2:0] {
    PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } phase_t;

  localparam int unused_sysclk_tcy = SYSCLK_TCY;

  phase_t      phase, phase_next;
  logic        clk2_q;
  logic        tick;
  logic        accept;
  logic        active_q;
  logic        taken_q;
  logic        pend_valid_q;
  logic [11:0] pend_addr_q;
  logic [11:0] cur_addr_q;
  logic [3:0]  opr_q;

`ifdef MCS4_FETCH_IO_EN
  logic        pend_io_en_q, cur_io_en_q;
  logic [7:0]  pend_io_data_q, cur_io_data_q;
  logic        unused_clk1;
  assign unused_clk1 = clk1_pad;
`else
  logic        unused_inputs;
  assign unused_inputs = ^{clk1_pad, req_io_en, req_io_data};
`endif

  assign tick   = clk2_q & ~clk2_pad;
  assign accept = req_valid & req_ready;

  // Phase register. Reset parks the counter in X3, so the first free sysclk
  // can already take a request.
  always_ff @(posedge sysclk) begin
    if (poc_pad) phase <= PH_X3;
    else         phase <= phase_next;
  end

  // Next phase and bus outputs. The counter steps only on a tick and wraps
  // from X3 to A1. Nothing is driven in an idle cycle. req_ready is masked
  // while reset is high, because the phase is X3 during reset.
  always_comb begin
    phase_next = phase;
    req_ready  = 1'b0;
    data_oe    = 1'b0;
    data_out   = 4'h0;
    cmrom_pad  = 1'b0;
    if (tick) phase_next = phase_t'(phase + 3'd1);
    req_ready = (phase == PH_X3) && !taken_q && !poc_pad;
    if (active_q) begin
      case (phase)
        PH_A1: begin data_oe = 1'b1; data_out = cur_addr_q[3:0]; end
        PH_A2: begin data_oe = 1'b1; data_out = cur_addr_q[7:4]; end
        PH_A3: begin data_oe = 1'b1; data_out = cur_addr_q[11:8]; cmrom_pad = 1'b1; end
`ifdef MCS4_FETCH_IO_EN
        PH_X2: if (cur_io_en_q) begin
          data_oe = 1'b1; data_out = cur_io_data_q[7:4]; cmrom_pad = 1'b1;
        end
        PH_X3: if (cur_io_en_q) begin
          data_oe = 1'b1; data_out = cur_io_data_q[3:0];
        end
`endif
        default: ;
      endcase
    end
  end

  // Request latch and response path. An accepted request waits in the
  // pending registers until the tick that ends X3. It then becomes the
  // current cycle, so the X2/X3 I/O word of the running cycle is never
  // overwritten. A request accepted on that same tick edge goes straight in.
  // OPR is held internally and published together with OPA, so the rsp_*
  // outputs change only when rsp_valid pulses.
  always_ff @(posedge sysclk) begin
    if (poc_pad) begin
      clk2_q       <= 1'b0;
      active_q     <= 1'b0;
      taken_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 12'h000;
      cur_addr_q   <= 12'h000;
      opr_q        <= 4'h0;
      sync_pad     <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_addr     <= 12'h000;
      rsp_opr      <= 4'h0;
      rsp_opa      <= 4'h0;
`ifdef MCS4_FETCH_IO_EN
      pend_io_en_q   <= 1'b0;
      cur_io_en_q    <= 1'b0;
      pend_io_data_q <= 8'h00;
      cur_io_data_q  <= 8'h00;
`endif
    end else begin
      clk2_q    <= clk2_pad;
      sync_pad  <= (phase_next == PH_X3);
      rsp_valid <= 1'b0;
      if (accept) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= req_addr;
        taken_q      <= 1'b1;
`ifdef MCS4_FETCH_IO_EN
        pend_io_en_q   <= req_io_en;
        pend_io_data_q <= req_io_data;
`endif
      end
      if (tick) begin
        case (phase)
          PH_M1: if (active_q) opr_q <= data_in;
          PH_M2: if (active_q) begin
            rsp_valid <= 1'b1;
            rsp_addr  <= cur_addr_q;
            rsp_opr   <= opr_q;
            rsp_opa   <= data_in;
          end
          PH_X3: begin
            active_q     <= pend_valid_q | accept;
            cur_addr_q   <= accept ? req_addr : pend_addr_q;
            pend_valid_q <= 1'b0;
            taken_q      <= 1'b0;
`ifdef MCS4_FETCH_IO_EN
            cur_io_en_q   <= accept ? req_io_en : pend_io_en_q;
            cur_io_data_q <= accept ? req_io_data : pend_io_data_q;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcs4_fetch_master.sv
// Testbench for mcs4_fetch_master.
//   It uses a table of fetch vectors with hand-computed bus nibbles, a small
//   clockgen model that produces one clk2 fall every 4 sysclks, a phase model
//   driven by those clk2 falls, and a ROM model that drives OPR in M1 and OPA
//   in M2.
module tb_mcs4_fetch_master;

  logic        sysclk = 1'b0;
  logic        poc_pad, clk1_pad, clk2_pad;
  logic        sync_pad, cmrom_pad, data_oe;
  logic [3:0]  data_in, data_out;
  logic        req_valid, req_ready, req_io_en;
  logic [11:0] req_addr;
  logic [7:0]  req_io_data;
  logic        rsp_valid;
  logic [11:0] rsp_addr;
  logic [3:0]  rsp_opr, rsp_opa;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  opr, opa;
    logic        io_en;
    logic [7:0]  io_data;
    logic [3:0]  n0, n1, n2;
    logic [3:0]  io_hi, io_lo;
  } vec_t;
  vec_t vecs[4];

  logic [3:0] rom_opr = 4'h0, rom_opa = 4'h0;
  int         tb_phase = 7;
  logic       tb_first = 1'b0;
  logic       clk2_prev = 1'b0;
  int         cg = 0;

  mcs4_fetch_master #(.SYSCLK_TCY(50)) dut (
    .sysclk(sysclk), .poc_pad(poc_pad), .clk1_pad(clk1_pad), .clk2_pad(clk2_pad),
    .sync_pad(sync_pad), .cmrom_pad(cmrom_pad), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(req_ready), .req_io_en(req_io_en),
    .req_io_data(req_io_data), .rsp_valid(rsp_valid), .rsp_addr(rsp_addr),
    .rsp_opr(rsp_opr), .rsp_opa(rsp_opa)
  );

  always #5 sysclk = ~sysclk;

  // clockgen model: clk1 and clk2 change on the falling sysclk edge
  initial begin
    clk1_pad = 1'b0;
    clk2_pad = 1'b0;
    forever begin
      @(negedge sysclk);
      cg = (cg + 1) % 4;
      clk1_pad = (cg == 0);
      clk2_pad = (cg == 2);
    end
  end

  // Reference phase model: 0=A1 .. 7=X3. tb_first marks the first sysclk of a phase.
  always @(posedge sysclk) begin
    if (poc_pad) begin
      tb_phase  <= 7;
      tb_first  <= 1'b0;
      clk2_prev <= 1'b0;
    end else begin
      clk2_prev <= clk2_pad;
      if (clk2_prev && !clk2_pad) begin
        tb_phase <= (tb_phase + 1) % 8;
        tb_first <= 1'b1;
      end else begin
        tb_first <= 1'b0;
      end
    end
  end

  // ROM model
  initial begin
    data_in = 4'h0;
    forever begin
      @(negedge sysclk);
      data_in = (tb_phase == 3) ? rom_opr : (tb_phase == 4) ? rom_opa : 4'h0;
    end
  end

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitPhase(input int p);
    for (int n = 0; n < 200; n++) begin
      @(negedge sysclk);
      if (tb_phase == p && tb_first) return;
    end
    checkOutput("phase_timeout", 12'd0, 12'(p + 1));
  endtask

  // Present a request and wait for its handshake. Return on the negedge after the accept edge.
  task automatic applyStimulus(input vec_t v, input bit hold);
    int n;
    @(negedge sysclk);
    req_valid   = 1'b1;
    req_addr    = v.addr;
    req_io_en   = v.io_en;
    req_io_data = v.io_data;
    #1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge sysclk);
      #1;
      n++;
    end
    if (n >= 200) checkOutput("accept_timeout", 12'd0, 12'd1);
    @(negedge sysclk);
    if (!hold) req_valid = 1'b0;
  endtask

  // Check one active cycle, from A1 to the first sysclk of its X3.
  task automatic runCycle(input vec_t v);
    logic       x_oe;
    logic [3:0] x2_out, x3_out;
    logic       x2_cm;
    rom_opr = v.opr;
    rom_opa = v.opa;
`ifdef MCS4_FETCH_IO_EN
    x_oe   = v.io_en;
    x2_out = v.io_en ? v.io_hi : 4'h0;
    x3_out = v.io_en ? v.io_lo : 4'h0;
    x2_cm  = v.io_en;
`else
    x_oe = 1'b0; x2_out = 4'h0; x3_out = 4'h0; x2_cm = 1'b0;
`endif
    waitPhase(0);
    checkOutput("a1_oe", 12'(data_oe), 12'd1);
    checkOutput("a1_out", 12'(data_out), 12'(v.n0));
    checkOutput("a1_sync", 12'(sync_pad), 12'd0);
    waitPhase(1);
    checkOutput("a2_out", 12'(data_out), 12'(v.n1));
    checkOutput("a2_cmrom", 12'(cmrom_pad), 12'd0);
    waitPhase(2);
    checkOutput("a3_out", 12'(data_out), 12'(v.n2));
    checkOutput("a3_cmrom", 12'(cmrom_pad), 12'd1);
    waitPhase(3);
    checkOutput("m1_oe", 12'(data_oe), 12'd0);
    checkOutput("m1_cmrom", 12'(cmrom_pad), 12'd0);
    waitPhase(5);
    checkOutput("x1_rsp_valid", 12'(rsp_valid), 12'd1);
    checkOutput("x1_rsp_addr", rsp_addr, v.addr);
    checkOutput("x1_rsp_opr", 12'(rsp_opr), 12'(v.opr));
    checkOutput("x1_rsp_opa", 12'(rsp_opa), 12'(v.opa));
    checkOutput("x1_oe", 12'(data_oe), 12'd0);
    waitPhase(6);
    checkOutput("x2_rsp_valid", 12'(rsp_valid), 12'd0);
    checkOutput("x2_oe", 12'(data_oe), 12'(x_oe));
    checkOutput("x2_out", 12'(data_out), 12'(x2_out));
    checkOutput("x2_cmrom", 12'(cmrom_pad), 12'(x2_cm));
    waitPhase(7);
    checkOutput("x3_sync", 12'(sync_pad), 12'd1);
    checkOutput("x3_oe", 12'(data_oe), 12'(x_oe));
    checkOutput("x3_out", 12'(data_out), 12'(x3_out));
    checkOutput("x3_cmrom", 12'(cmrom_pad), 12'd0);
    checkOutput("x3_ready", 12'(req_ready), 12'd1);
    checkOutput("x3_rsp_hold", rsp_addr, v.addr);
  endtask

  initial begin
    int sync_rises, oe_hits, rsp_hits;
    logic sync_prev;

    vecs[0] = '{addr: 12'h5A3, opr: 4'hD, opa: 4'h7, io_en: 1'b0, io_data: 8'h00,
                n0: 4'h3, n1: 4'hA, n2: 4'h5, io_hi: 4'h0, io_lo: 4'h0};
    vecs[1] = '{addr: 12'h000, opr: 4'h1, opa: 4'h2, io_en: 1'b0, io_data: 8'h00,
                n0: 4'h0, n1: 4'h0, n2: 4'h0, io_hi: 4'h0, io_lo: 4'h0};
    vecs[2] = '{addr: 12'hFFF, opr: 4'hE, opa: 4'hF, io_en: 1'b0, io_data: 8'h00,
                n0: 4'hF, n1: 4'hF, n2: 4'hF, io_hi: 4'h0, io_lo: 4'h0};
    vecs[3] = '{addr: 12'h9C4, opr: 4'h8, opa: 4'hB, io_en: 1'b1, io_data: 8'h3C,
                n0: 4'h4, n1: 4'hC, n2: 4'h9, io_hi: 4'h3, io_lo: 4'hC};

    poc_pad = 1'b1;
    req_valid = 1'b0;
    req_addr = 12'h000;
    req_io_en = 1'b0;
    req_io_data = 8'h00;

    $display("[TB] reset");
    repeat (3) @(negedge sysclk);
    checkOutput("rst_sync", 12'(sync_pad), 12'd1);
    checkOutput("rst_ready", 12'(req_ready), 12'd0);
    checkOutput("rst_oe", 12'(data_oe), 12'd0);
    checkOutput("rst_cmrom", 12'(cmrom_pad), 12'd0);
    checkOutput("rst_out", 12'(data_out), 12'd0);
    checkOutput("rst_rsp_addr", rsp_addr, 12'd0);
    poc_pad = 1'b0;
    #1;
    checkOutput("post_rst_ready", 12'(req_ready), 12'd1);
    checkOutput("post_rst_sync", 12'(sync_pad), 12'd1);
    checkOutput("post_rst_rsp_valid", 12'(rsp_valid), 12'd0);
    checkOutput("post_rst_opr", 12'(rsp_opr), 12'd0);

    $display("[TB] table-driven single fetches");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i], 1'b0);
      runCycle(vecs[i]);
    end

    $display("[TB] two idle cycles");
    waitPhase(0);
    sync_rises = 0; oe_hits = 0; rsp_hits = 0; sync_prev = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge sysclk);
      if (sync_pad && !sync_prev) sync_rises++;
      if (data_oe) oe_hits++;
      if (rsp_valid) rsp_hits++;
      sync_prev = sync_pad;
    end
    checkOutput("idle_sync_pulses", 12'(sync_rises), 12'd2);
    checkOutput("idle_oe", 12'(oe_hits), 12'd0);
    checkOutput("idle_rsp", 12'(rsp_hits), 12'd0);

    $display("[TB] back-to-back with req_valid held");
    applyStimulus(vecs[1], 1'b1);
    req_addr = vecs[2].addr;
    runCycle(vecs[1]);
    @(negedge sysclk);
    checkOutput("b2b_accept_once", 12'(req_ready), 12'd0);
    req_valid = 1'b0;
    runCycle(vecs[2]);

    $display("[TB] reset during M1");
    applyStimulus(vecs[0], 1'b0);
    waitPhase(3);
    poc_pad = 1'b1;
    @(negedge sysclk);
    poc_pad = 1'b0;
    rsp_hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge sysclk);
      if (rsp_valid) rsp_hits++;
    end
    checkOutput("abort_no_rsp", 12'(rsp_hits), 12'd0);
    checkOutput("abort_rsp_addr", rsp_addr, 12'd0);
    applyStimulus(vecs[3], 1'b0);
    runCycle(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
